// File: rtl/switch_debouncer_if.sv
// Switch-conditioning bus: raw pins in, debounced level and edge pulses out.
interface switch_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] switches_in;
    logic [WIDTH-1:0] switches_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (output switches_in, input switches_out, rise, fall, changed);
    modport slave  (input switches_in, output switches_out, rise, fall, changed);
endinterface

// File: rtl/switch_debouncer.sv
// Per-channel synchroniser + stability-counter debouncer for board switches.
// Define SWITCH_DEBOUNCE_PULSE_EN to build the rise/fall/changed pulse registers.
module switch_debouncer_lane #(
    parameter int STABLE_CYCLES = 1250000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_o
);
    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    // Any agreement with the output throws away partial progress.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (sync == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            out_d = sync;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign out_o = out_q;

`ifdef SWITCH_DEBOUNCE_PULSE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign evt_o  = out_d ^ out_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
    assign evt_o  = 1'b0;
`endif
endmodule

module switch_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 1250000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    switch_debouncer_if.slave bus
);
    logic [WIDTH-1:0] lane_out;
    logic [WIDTH-1:0] lane_rise;
    logic [WIDTH-1:0] lane_fall;
    logic [WIDTH-1:0] lane_evt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        switch_debouncer_lane #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .pin_i (bus.switches_in[g]),
            .out_o (lane_out[g]),
            .rise_o(lane_rise[g]),
            .fall_o(lane_fall[g]),
            .evt_o (lane_evt[g])
        );
    end

    assign bus.switches_out = lane_out;
    assign bus.rise         = lane_rise;
    assign bus.fall         = lane_fall;

`ifdef SWITCH_DEBOUNCE_PULSE_EN
    logic changed_q;

    // Registered from the lanes' next-state so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= |lane_evt;
    end

    assign bus.changed = changed_q;
`else
    assign bus.changed = |lane_evt;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed + random bench for switch_debouncer against a sliding-window reference model.
module tb_switch_debouncer;
    localparam int W  = 2;
    localparam int SC = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pin;

    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(W)) bus ();
    assign bus.switches_in = pin;

    switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model: hist[k] is the pin value sampled k+1 edges ago (zeros after reset).
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out, m_rise, m_fall;
    logic         m_chg;
    int           checks = 0;
    int           passed = 0;
    bit           pulses_on;

    task automatic model_step(input logic r, input logic [W-1:0] p);
        logic [W-1:0] nxt;
        bit           all;
        if (r) begin
            hist.delete();
            for (int i = 0; i < SS + SC; i++) hist.push_back('0);
            m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        end else begin
            nxt = m_out;
            // Flip when the last SC synchronised samples all disagree with the output.
            for (int c = 0; c < W; c++) begin
                all = 1'b1;
                for (int k = SS - 1; k < SS - 1 + SC; k++)
                    if (hist[k][c] == m_out[c]) all = 1'b0;
                if (all) nxt[c] = ~m_out[c];
            end
            m_rise = pulses_on ? (nxt & ~m_out) : '0;
            m_fall = pulses_on ? (~nxt & m_out) : '0;
            m_chg  = |(m_rise | m_fall);
            m_out  = nxt;
            hist.push_front(p);
            void'(hist.pop_back());
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic cyc(input logic r, input logic [W-1:0] p);
        rst = r;
        pin = p;
        @(posedge clk);
        model_step(r, p);
        #1;
        chk("out",  bus.switches_out, m_out);
        chk("rise", bus.rise, m_rise);
        chk("fall", bus.fall, m_fall);
        chk("chg",  {1'b0, bus.changed}, {1'b0, m_chg});
    endtask

    task automatic hold(input logic [W-1:0] p, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, p);
    endtask

    initial begin
`ifdef SWITCH_DEBOUNCE_PULSE_EN
        pulses_on = 1'b1;
`else
        pulses_on = 1'b0;
`endif
        rst = 1'b1;
        pin = 2'b11;

        // Reset with both switches held high, then full latency to the rise.
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b11);
        chk("rst_out", bus.switches_out, 2'b00);
        hold(2'b11, 9);
        chk("rst_lat_early", bus.switches_out, 2'b00);
        hold(2'b11, 1);
        chk("rst_lat_out", bus.switches_out, 2'b11);
        chk("rst_lat_rise", bus.rise, pulses_on ? 2'b11 : 2'b00);
        hold(2'b11, 2);

        // Clean step and release on channel 0.
        for (int i = 0; i < 2; i++) cyc(1'b1, 2'b00);
        hold(2'b00, 4);
        hold(2'b01, 9);
        chk("step_early", bus.switches_out, 2'b00);
        hold(2'b01, 1);
        chk("step_out", bus.switches_out, 2'b01);
        chk("step_rise", bus.rise, pulses_on ? 2'b01 : 2'b00);
        hold(2'b01, 4);
        hold(2'b00, 10);
        chk("rel_out", bus.switches_out, 2'b00);
        chk("rel_fall", bus.fall, pulses_on ? 2'b01 : 2'b00);
        hold(2'b00, 3);

        // Glitches one cycle short of the threshold on channel 1.
        hold(2'b10, 7);
        hold(2'b00, 12);
        hold(2'b10, 7);
        hold(2'b00, 1);
        hold(2'b10, 7);
        hold(2'b00, 12);
        chk("glitch_out", bus.switches_out, 2'b00);

        // Both channels change on the same edge.
        hold(2'b11, 10);
        chk("sim_out", bus.switches_out, 2'b11);
        chk("sim_chg", {1'b0, bus.changed}, {1'b0, pulses_on});
        hold(2'b11, 1);
        chk("sim_chg_once", {1'b0, bus.changed}, 2'b00);
        hold(2'b00, 12);

        // Reset five cycles into a debounce restarts the full latency.
        hold(2'b11, 5);
        for (int i = 0; i < 2; i++) cyc(1'b1, 2'b11);
        hold(2'b11, 9);
        chk("midrst_early", bus.switches_out, 2'b00);
        hold(2'b11, 1);
        chk("midrst_out", bus.switches_out, 2'b11);
        hold(2'b11, 3);

        // Random bursts with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] p;
            p = pin;
            if ($urandom_range(5) == 0) p[$urandom_range(W - 1)] ^= 1'b1;
            cyc(($urandom_range(299) == 0), p);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
